csr_counter_unit: RTL
=====================

// Module: csr_counter_unit
// PURPOSE
//  Execute-stage consumer of the decoded CSR operation (CsrOp_t) from ID.
//  Holds the Zicntr 64-bit counters: cycle, time and instret.
//  Services CSRRS reads with a 1-cycle registered result that feeds the EX/MEM result mux.
//  Flags illegal CSR accesses to the trap logic.
// PARAMETERS
//  CNT_W     64  counter width; read halves are always 32 bits
//  TIME_DIV  1   clk cycles per time increment; must be >= 1
// PORTS
//  clk             in   1   core clock
//  resetn          in   1   asynchronous active-low reset
//  csr_op_e        in   $bits(CsrOp_t)  decoded CSR op, registered into EX
//  csr_addr_e      in   12  instr[31:20]
//  rs1_nz_e        in   1   rs1 field != x0 (CSRRS would write)
//  valid_e         in   1   EX holds a real instruction this cycle
//  stall_e         in   1   EX held; do not accept, hold outputs
//  flush_e         in   1   kill EX instruction; no read issued
//  retire_w        in   1   one instruction retired in WB this cycle
//  csr_rdata_m     out  32  read result (registered)
//  csr_rvalid_m    out  1   csr_rdata_m valid this cycle
//  csr_illegal_m   out  1   illegal access (registered, same timing as rvalid)
// BEHAVIOUR
//  Reset (resetn=0, asynchronous): all counters 0, prescaler 0; csr_rdata_m=0, csr_rvalid_m=0, csr_illegal_m=0.
//  Accept condition: acc = valid_e & ~stall_e & ~flush_e & (csr_op_e==CSR_OP_CSRRS).
//  Address map (read-only):
//    C00 cycle[31:0]    C01 time[31:0]    C02 instret[31:0]
//    C80 cycle[63:32]   C81 time[63:32]   C82 instret[63:32]
//  Any other address, or rs1_nz_e=1 to a mapped address: illegal.
//    Illegal access gives rdata=0, illegal=1, rvalid=1.
//  Latency: acc in cycle N -> rvalid/rdata/illegal in cycle N+1.
//    Data is the counter value at the start of cycle N, i.e. pre-increment.
//  Output regs:
//    ~acc & ~stall_e: next cycle rvalid=0, illegal=0, rdata unchanged.
//    stall_e: all three hold their values.
//  cycle: +1 every clk after reset release, regardless of stall or flush.
//  time: prescaler counts 0..TIME_DIV-1; time increments on the prescaler wrap.
//    TIME_DIV=1 means time increments every clk.
//  instret: +1 when retire_w=1.
//    A read of instret in the same cycle as retire_w returns the old value.
//  Wrap-around: all counters wrap modulo 2^CNT_W silently.
//    The low->high carry lands in the same cycle as the low-half wrap.
//  Split reads are not atomic: software uses the hi/lo/hi retry sequence.
//  flush_e together with valid_e: no access, rvalid=0 next cycle. Counters are unaffected.
//  Reset mid-read: a pending rvalid is cleared immediately (asynchronous).
// STRUCTURE
//  Shared defines (riscv_defines.svh):
//    CsrOp_t (existing)
//    CSR_ADDR_CYCLE/TIME/INSTRET and the *H variants as 12-bit localparams
//  Sub-module csr_counter64 (instantiated 3x): clk, resetn, inc, out count[CNT_W-1:0].
//  Top contains the prescaler, the address decode/mux, the illegal logic and the output registers.
// TESTING
//  Release reset, idle 10 clk, then CSRRS C00 rs1=x0
//    -> next cycle rvalid=1, rdata=10, illegal=0.
//  Preload cycle=0x0000_0000_FFFF_FFFF via force, read C80 after 1 clk
//    -> rdata=0x1; C00 read gives 0x0000_0000 + elapsed.
//  retire_w=1 and read C02 in the same cycle with instret=5
//    -> rdata=5; the following read gives 6.
//  CSRRS C00 with rs1_nz_e=1, then CSRRS 0x7C0
//    -> both give illegal=1, rdata=0, rvalid=1.
//  stall_e=1 for 3 cycles after an accepted read
//    -> rvalid/rdata held for 3 cycles; flush_e on a CSRRS -> rvalid=0.
//  TIME_DIV=4, 16 clk after reset, read C01
//    -> rdata=4; assert resetn=0 mid-read -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/csr_counter_unit_pkg.sv
// Shared CSR definitions for the execute-stage counter unit: decoded op type,
// Zicntr counter addresses and the read-address decoder.
package csr_counter_unit_pkg;

    typedef enum logic [2:0] {
        CSR_OP_NONE  = 3'd0,
        CSR_OP_CSRRW = 3'd1,
        CSR_OP_CSRRS = 3'd2,
        CSR_OP_CSRRC = 3'd3,
        CSR_OP_CSRRWI = 3'd4,
        CSR_OP_CSRRSI = 3'd5,
        CSR_OP_CSRRCI = 3'd6
    } CsrOp_t;

    localparam int CSR_OP_W = $bits(CsrOp_t);

    localparam logic [11:0] CSR_ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_ADDR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_ADDR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_ADDR_INSTRETH = 12'hC82;

    localparam logic [1:0] CNT_SEL_CYCLE   = 2'd0;
    localparam logic [1:0] CNT_SEL_TIME    = 2'd1;
    localparam logic [1:0] CNT_SEL_INSTRET = 2'd2;

    typedef struct packed {
        logic       hit;
        logic       hi;
        logic [1:0] sel;
    } csr_dec_t;

    // Maps a CSR address onto a counter and half; hit=0 for unmapped addresses.
    function automatic csr_dec_t csr_decode(input logic [11:0] addr);
        csr_dec_t d;
        d = '0;
        case (addr)
            CSR_ADDR_CYCLE:    begin d.hit = 1'b1; d.sel = CNT_SEL_CYCLE;   end
            CSR_ADDR_TIME:     begin d.hit = 1'b1; d.sel = CNT_SEL_TIME;    end
            CSR_ADDR_INSTRET:  begin d.hit = 1'b1; d.sel = CNT_SEL_INSTRET; end
            CSR_ADDR_CYCLEH:   begin d.hit = 1'b1; d.hi = 1'b1; d.sel = CNT_SEL_CYCLE;   end
            CSR_ADDR_TIMEH:    begin d.hit = 1'b1; d.hi = 1'b1; d.sel = CNT_SEL_TIME;    end
            CSR_ADDR_INSTRETH: begin d.hit = 1'b1; d.hi = 1'b1; d.sel = CNT_SEL_INSTRET; end
            default:           d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/csr_counter_unit_counter64.sv
// Free-running wrap-around counter with an increment enable; one full-width
// adder so the low-to-high carry lands in the same cycle as the low-half wrap.
module csr_counter64 #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_counter_unit.sv
// Execute-stage Zicntr unit: cycle/time/instret counters, CSRRS read decode
// and a one-cycle registered read result with an illegal-access flag.
module csr_counter_unit
    import csr_counter_unit_pkg::*;
#(
    parameter int CNT_W    = 64,
    parameter int TIME_DIV = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CSR_OP_W-1:0] csr_op_e,
    input  logic [11:0]         csr_addr_e,
    input  logic                rs1_nz_e,
    input  logic                valid_e,
    input  logic                stall_e,
    input  logic                flush_e,
    input  logic                retire_w,
    output logic [31:0]         csr_rdata_m,
    output logic                csr_rvalid_m,
    output logic                csr_illegal_m
);

    localparam int PRE_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             pre_wrap;

    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] time_cnt;
    logic [CNT_W-1:0] instret_cnt;

    csr_dec_t         dec;
    logic             acc;
    logic             illegal;
    logic [63:0]      sel_cnt;
    logic [31:0]      rd_mux;

    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             rvalid_q;
    logic             rvalid_d;
    logic             illegal_q;
    logic             illegal_d;

    // With TIME_DIV=1 the prescaler sits at 0 and wraps every cycle.
    assign pre_wrap = (pre_q == PRE_W'(TIME_DIV - 1));
    assign pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    csr_counter64 #(.CNT_W(CNT_W)) u_cycle (
        .clk    (clk),
        .resetn (resetn),
        .inc    (1'b1),
        .count  (cycle_cnt)
    );

    csr_counter64 #(.CNT_W(CNT_W)) u_time (
        .clk    (clk),
        .resetn (resetn),
        .inc    (pre_wrap),
        .count  (time_cnt)
    );

    csr_counter64 #(.CNT_W(CNT_W)) u_instret (
        .clk    (clk),
        .resetn (resetn),
        .inc    (retire_w),
        .count  (instret_cnt)
    );

    assign dec     = csr_decode(csr_addr_e);
    assign acc     = valid_e & ~stall_e & ~flush_e & (csr_op_e == CSR_OP_CSRRS);
    // Counters are read-only: a CSRRS that would write (rs1 != x0) traps.
    assign illegal = ~dec.hit | rs1_nz_e;

    always_comb begin
        sel_cnt = '0;
        case (dec.sel)
            CNT_SEL_CYCLE:   sel_cnt = 64'(cycle_cnt);
            CNT_SEL_TIME:    sel_cnt = 64'(time_cnt);
            CNT_SEL_INSTRET: sel_cnt = 64'(instret_cnt);
            default:         sel_cnt = '0;
        endcase
    end

    assign rd_mux = dec.hi ? sel_cnt[63:32] : sel_cnt[31:0];

    always_comb begin
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        illegal_d = illegal_q;
        if (!stall_e) begin
            rvalid_d  = acc;
            illegal_d = acc & illegal;
            if (acc) begin
                rdata_d = illegal ? 32'h0 : rd_mux;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            illegal_q <= illegal_d;
        end
    end

    assign csr_rdata_m   = rdata_q;
    assign csr_rvalid_m  = rvalid_q;
    assign csr_illegal_m = illegal_q;

endmodule
